// File: rtl/reg_writeback_queue_pkg.sv
// Shared core types for the writeback queue: register/data widths, the zero register
// and the {reg, data} writeback entry.
package reg_writeback_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 64;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] r);
        return r == ZERO_REG;
    endfunction

endpackage

// File: rtl/wb_fwd_search.sv
// Forwarding search for one lookup port: youngest matching pending write wins,
// output stage is the oldest candidate.
module wb_fwd_search
    import reg_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]     entries,   // age ordered, index 0 is the oldest
    input  logic [$clog2(DEPTH):0]    count,
    input  wb_entry_t                 out_entry,
    input  logic                      out_valid,
    input  logic [REG_ADDR_W-1:0]     lookup,
    output logic                      hit,
    output logic [DATA_W-1:0]         data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] slot_live;
    logic [DEPTH-1:0] slot_match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_live[gi]  = CNT_W'(gi) < count;
            assign slot_match[gi] = slot_live[gi] && (entries[gi].reg_addr == lookup);
        end
    endgenerate

    // Later (younger) slots override earlier ones, so the loop order encodes priority.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (!is_zero_reg(lookup)) begin
            if (out_valid && (out_entry.reg_addr == lookup)) begin
                hit  = 1'b1;
                data = out_entry.data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (slot_match[k]) begin
                    hit  = 1'b1;
                    data = entries[k].data;
                end
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// Merges ALU and load writebacks into one ordered queue feeding a registered
// register-file write port, with bypass lookup over all pending writes.
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_W-1:0]     alu_reg,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      mem_valid,
    input  logic [REG_ADDR_W-1:0]     mem_reg,
    input  logic [DATA_W-1:0]         mem_data,
    output logic                      in_ready,
    output logic [REG_ADDR_W-1:0]     write_reg,
    output logic [DATA_W-1:0]         write_data,
    output logic                      reg_write_enable,
    input  logic [REG_ADDR_W-1:0]     lookup_a,
    input  logic [REG_ADDR_W-1:0]     lookup_b,
    output logic                      fwd_hit_a,
    output logic [DATA_W-1:0]         fwd_data_a,
    output logic                      fwd_hit_b,
    output logic [DATA_W-1:0]         fwd_data_b,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t                store [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]         count_reg, count_next;
    wb_entry_t                out_entry_reg;
    logic                     out_valid_reg;

    logic                     alu_push, mem_push, pop;
    logic [PTR_W-1:0]         mem_slot;
    wb_entry_t                alu_entry, mem_entry;
    wb_entry_t [DEPTH-1:0]    ordered;

    // Ready looks only at registered occupancy so two pushes always fit.
    assign in_ready = count_reg <= CNT_W'(DEPTH - 2);

    assign alu_push = alu_valid && in_ready && !is_zero_reg(alu_reg);
    assign mem_push = mem_valid && in_ready && !is_zero_reg(mem_reg);
    assign pop      = count_reg != '0;

    assign alu_entry = '{reg_addr: alu_reg, data: alu_data};
    assign mem_entry = '{reg_addr: mem_reg, data: mem_data};
    assign mem_slot  = wr_ptr_reg + PTR_W'(alu_push);

    assign wr_ptr_next = wr_ptr_reg + PTR_W'(alu_push) + PTR_W'(mem_push);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    assign count_next  = count_reg + CNT_W'(alu_push) + CNT_W'(mem_push) - CNT_W'(pop);

    // Entry storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            store[wr_ptr_reg] <= alu_entry;
        end
        if (mem_push) begin
            store[mem_slot] <= mem_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_entry_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            out_valid_reg <= pop;
            if (pop) begin
                out_entry_reg <= store[rd_ptr_reg];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_order
            assign ordered[gi] = store[rd_ptr_reg + PTR_W'(gi)];
        end
    endgenerate

    wb_fwd_search #(.DEPTH(DEPTH)) u_fwd_a (
        .entries   (ordered),
        .count     (count_reg),
        .out_entry (out_entry_reg),
        .out_valid (out_valid_reg),
        .lookup    (lookup_a),
        .hit       (fwd_hit_a),
        .data      (fwd_data_a)
    );

    wb_fwd_search #(.DEPTH(DEPTH)) u_fwd_b (
        .entries   (ordered),
        .count     (count_reg),
        .out_entry (out_entry_reg),
        .out_valid (out_valid_reg),
        .lookup    (lookup_b),
        .hit       (fwd_hit_b),
        .data      (fwd_data_b)
    );

    assign write_reg        = out_entry_reg.reg_addr;
    assign write_data       = out_entry_reg.data;
    assign reg_write_enable = out_valid_reg;
    assign count            = count_reg;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench: a queue-based reference model predicts writes, occupancy and
// bypass results; a negedge monitor compares them against the DUT.
module tb_reg_writeback_queue;
    import reg_writeback_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_reg = '0, mem_reg = '0, lookup_a = '0, lookup_b = '0;
    logic [63:0] alu_data = '0, mem_data = '0;
    logic        in_ready, reg_write_enable, fwd_hit_a, fwd_hit_b;
    logic [4:0]  write_reg;
    logic [63:0] write_data, fwd_data_a, fwd_data_b;
    logic [2:0]  count;

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
        .in_ready(in_ready), .write_reg(write_reg), .write_data(write_data),
        .reg_write_enable(reg_write_enable),
        .lookup_a(lookup_a), .lookup_b(lookup_b),
        .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
        .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
        .count(count)
    );

    // Reference model: pending writes in age order plus the one being written.
    wb_entry_t pend[$];
    wb_entry_t sb[$];
    wb_entry_t out_m = '0;
    logic      out_v = 1'b0;
    bit        alu_taken, mem_taken, mon_en;
    int        checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rdy;
        rdy = pend.size() <= DEPTH - 2;
        if (pend.size() > 0) begin
            out_m = pend.pop_front();
            out_v = 1'b1;
        end else begin
            out_v = 1'b0;
        end
        alu_taken = alu_valid && rdy;
        mem_taken = mem_valid && rdy;
        if (alu_taken && alu_reg != 5'd31) begin
            pend.push_back('{reg_addr: alu_reg, data: alu_data});
            sb.push_back('{reg_addr: alu_reg, data: alu_data});
        end
        if (mem_taken && mem_reg != 5'd31) begin
            pend.push_back('{reg_addr: mem_reg, data: mem_data});
            sb.push_back('{reg_addr: mem_reg, data: mem_data});
        end
    endtask

    function automatic void fwd_exp(input logic [4:0] lk, output logic h, output logic [63:0] d);
        h = 1'b0;
        d = '0;
        if (lk == 5'd31) return;
        if (out_v && out_m.reg_addr == lk) begin
            h = 1'b1;
            d = out_m.data;
        end
        foreach (pend[i]) begin
            if (pend[i].reg_addr == lk) begin
                h = 1'b1;
                d = pend[i].data;
            end
        end
    endfunction

    always @(negedge clk) begin : monitor
        logic      h;
        logic [63:0] d;
        wb_entry_t e;
        if (mon_en && !reset) begin
            chk("count", 64'(count), 64'(pend.size()));
            chk("in_ready", 64'(in_ready), 64'(pend.size() <= DEPTH - 2));
            chk("write_enable", 64'(reg_write_enable), 64'(out_v));
            if (reg_write_enable) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write",
                             write_reg, write_data);
                end else begin
                    e = sb.pop_front();
                    chk("write_reg", 64'(write_reg), 64'(e.reg_addr));
                    chk("write_data", write_data, e.data);
                end
            end else begin
                chk("hold_reg", 64'(write_reg), 64'(out_m.reg_addr));
                chk("hold_data", write_data, out_m.data);
            end
            fwd_exp(lookup_a, h, d);
            chk("fwd_hit_a", 64'(fwd_hit_a), 64'(h));
            chk("fwd_data_a", fwd_data_a, d);
            fwd_exp(lookup_b, h, d);
            chk("fwd_hit_b", 64'(fwd_hit_b), 64'(h));
            chk("fwd_data_b", fwd_data_b, d);
        end
    end

    task automatic drive(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [63:0] md);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
    endtask

    // Asserted just after an edge; outputs are checked before the next edge.
    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        chk("rst_write_enable", 64'(reg_write_enable), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_write_reg", 64'(write_reg), 64'd0);
        chk("rst_write_data", write_data, 64'd0);
        chk("rst_fwd_hit_a", 64'(fwd_hit_a), 64'd0);
        chk("rst_fwd_hit_b", 64'(fwd_hit_b), 64'd0);
        pend.delete();
        sb.delete();
        out_m = '0;
        out_v = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        #1;
        do_reset();
        mon_en = 1'b1;

        // Single ALU write into an empty queue.
        lookup_a = 5'd3; lookup_b = 5'd6;
        drive(1'b1, 5'd3, 64'h1234, 1'b0, 5'd0, 64'd0);
        tick();
        chk("t27_count", 64'(count), 64'd1);
        idle();
        tick();
        chk("t27_we", 64'(reg_write_enable), 64'd1);
        chk("t27_reg", 64'(write_reg), 64'd3);
        chk("t27_data", write_data, 64'h1234);
        tick();
        chk("t27_we_off", 64'(reg_write_enable), 64'd0);
        chk("t27_hold_data", write_data, 64'h1234);

        // Simultaneous ALU and MEM: ALU is older.
        drive(1'b1, 5'd1, 64'hA, 1'b1, 5'd2, 64'hB);
        tick();
        chk("t28_count2", 64'(count), 64'd2);
        idle();
        tick();
        chk("t28_count1", 64'(count), 64'd1);
        chk("t28_first_reg", 64'(write_reg), 64'd1);
        tick();
        chk("t28_count0", 64'(count), 64'd0);
        chk("t28_second_reg", 64'(write_reg), 64'd2);
        tick();

        // Two pending writes to reg 5: the younger one forwards.
        lookup_a = 5'd5; lookup_b = 5'd6;
        drive(1'b1, 5'd5, 64'h10, 1'b1, 5'd5, 64'h20);
        tick();
        chk("t30_hit_a", 64'(fwd_hit_a), 64'd1);
        chk("t30_data_a", fwd_data_a, 64'h20);
        chk("t30_hit_b", 64'(fwd_hit_b), 64'd0);
        idle();
        repeat (3) tick();

        // Writes to the zero register are swallowed.
        lookup_a = 5'd31;
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hDEAD);
        tick();
        chk("t31_count", 64'(count), 64'd0);
        idle();
        tick();
        chk("t31_we", 64'(reg_write_enable), 64'd0);
        chk("t31_hit_a", 64'(fwd_hit_a), 64'd0);

        // Fill at two per cycle: ready drops at occupancy 3, held request lands later.
        do_reset();
        drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
        tick();
        drive(1'b1, 5'd3, 64'h3, 1'b1, 5'd4, 64'h4);
        tick();
        chk("t29_count3", 64'(count), 64'd3);
        chk("t29_ready_low", 64'(in_ready), 64'd0);
        drive(1'b1, 5'd5, 64'h5, 1'b1, 5'd6, 64'h6);
        tick();
        chk("t29_stalled_count", 64'(count), 64'd2);
        tick();
        chk("t29_refill_count", 64'(count), 64'd3);
        idle();
        repeat (5) tick();

        // Reset in the middle of a drain.
        drive(1'b1, 5'd7, 64'h7, 1'b1, 5'd8, 64'h8);
        tick();
        drive(1'b1, 5'd9, 64'h9, 1'b1, 5'd10, 64'hA0);
        tick();
        lookup_a = 5'd8;
        do_reset();
        repeat (4) tick();

        // Randomized traffic with producers holding unaccepted requests.
        alu_taken = 1'b0; mem_taken = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!alu_valid || alu_taken) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_reg   = rand_reg();
                alu_data  = {$urandom, $urandom};
            end
            if (!mem_valid || mem_taken) begin
                mem_valid = ($urandom_range(0, 9) < 5);
                mem_reg   = rand_reg();
                mem_data  = {$urandom, $urandom};
            end
            lookup_a = rand_reg();
            lookup_b = rand_reg();
            if (i == 750) do_reset();
            else tick();
        end

        idle();
        for (int n = 0; n < 20 && (sb.size() != 0 || pend.size() != 0); n++) tick();
        tick();
        chk("drain_scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
